axi4lite_selftest_master: RTL and testbench

AXI4-Lite master that sits directly upstream of the axi4_status_regs slave and drives its S00_AXI port. On a start pulse it writes an incrementing pattern to NUM_REGS consecutive registers, reads each back, compares, and reports pass/fail. It is the synthesizable power-on/bring-up counterpart of the VIP write/readback sequence, for use in the SIMD processor system without a processor on the bus.

---
 rtl/axi4lite_selftest_master.sv | 198 +++++++++++++++++++
 tb/tb_axi4lite_selftest_master.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4lite_selftest_master.sv
// Purpose: AXI4-Lite bring-up master. On start it writes SEED+i to NUM_REGS
//          consecutive 32-bit registers, reads each back, compares, and reports pass/fail.
// Latency: done pulses 4*NUM_REGS+1 cycles after start is accepted when the slave has no wait states.
// Backpressure: every VALID is held with stable address/data until its handshake.
//               Only one transaction is outstanding. Extra slave wait states lengthen the run.
// Ports:   ACLK/ARESET (async, active-high), start/busy/done/pass/err_count/first_fail,
//          and the M_AXI_* AW/W/B/AR/R channels (no ID or burst signals).
module axi4lite_selftest_master #(
  parameter int unsigned                  C_M_AXI_ADDR_WIDTH = 32,
  parameter int unsigned                  C_M_AXI_DATA_WIDTH = 32,
  parameter int unsigned                  NUM_REGS           = 4,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] BASE_ADDR         = '0,
  parameter logic [C_M_AXI_DATA_WIDTH-1:0] SEED              = 1
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic                            start,
  output logic                            busy,
  output logic                            done,
  output logic                            pass,
  output logic [4:0]                      err_count,
  output logic [3:0]                      first_fail,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, FINISH} state_t;

  localparam logic [3:0] LAST_IDX = 4'(NUM_REGS - 1);

  state_t                          state_q;
  logic [3:0]                      idx_q;
  logic                            busy_q, done_q, pass_q, first_seen_q;
  logic [4:0]                      err_count_q, err_count_d;
  logic [3:0]                      first_fail_q;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   awaddr_q, araddr_q;
  logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q;
  logic                            awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;

  function automatic logic [C_M_AXI_ADDR_WIDTH-1:0] reg_addr(input logic [3:0] i);
    return BASE_ADDR + {{(C_M_AXI_ADDR_WIDTH-6){1'b0}}, i, 2'b00};
  endfunction

  function automatic logic [C_M_AXI_DATA_WIDTH-1:0] reg_data(input logic [3:0] i);
    return SEED + {{(C_M_AXI_DATA_WIDTH-4){1'b0}}, i};
  endfunction

  logic b_hs, r_hs, b_err, r_fail;
  assign b_hs   = M_AXI_BVALID & bready_q;
  assign r_hs   = M_AXI_RVALID & rready_q;
  assign b_err  = (state_q == WR_RESP) && b_hs && (M_AXI_BRESP != 2'b00);
  // A bad read beat counts once even when both the data and the response are wrong.
  assign r_fail = (state_q == RD_RESP) && r_hs &&
                  ((M_AXI_RDATA != reg_data(idx_q)) || (M_AXI_RRESP != 2'b00));

  always_comb begin
    err_count_d = err_count_q;
    if ((b_err || r_fail) && (err_count_q != 5'd31)) begin
      err_count_d = err_count_q + 5'd1;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      first_seen_q <= 1'b0;
      err_count_q  <= '0;
      first_fail_q <= '0;
      awaddr_q     <= '0;
      araddr_q     <= '0;
      wdata_q      <= '0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q      <= WR_REQ;
            idx_q        <= '0;
            err_count_q  <= '0;
            first_fail_q <= '0;
            first_seen_q <= 1'b0;
            pass_q       <= 1'b0;
            busy_q       <= 1'b1;
            awaddr_q     <= reg_addr(4'd0);
            wdata_q      <= reg_data(4'd0);
            awvalid_q    <= 1'b1;
            wvalid_q     <= 1'b1;
          end
        end
        WR_REQ: begin
          // AW and W retire independently; a channel whose VALID is already low is done.
          if (awvalid_q && M_AXI_AWREADY) awvalid_q <= 1'b0;
          if (wvalid_q && M_AXI_WREADY)   wvalid_q  <= 1'b0;
          if (!(awvalid_q && !M_AXI_AWREADY) && !(wvalid_q && !M_AXI_WREADY)) begin
            state_q  <= WR_RESP;
            bready_q <= 1'b1;
          end
        end
        WR_RESP: begin
          if (b_hs) begin
            bready_q    <= 1'b0;
            err_count_q <= err_count_d;
            if (idx_q == LAST_IDX) begin
              idx_q     <= '0;
              state_q   <= RD_REQ;
              araddr_q  <= reg_addr(4'd0);
              arvalid_q <= 1'b1;
            end else begin
              idx_q     <= idx_q + 4'd1;
              state_q   <= WR_REQ;
              awaddr_q  <= reg_addr(idx_q + 4'd1);
              wdata_q   <= reg_data(idx_q + 4'd1);
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
            end
          end
        end
        RD_REQ: begin
          if (arvalid_q && M_AXI_ARREADY) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= RD_RESP;
          end
        end
        RD_RESP: begin
          if (r_hs) begin
            rready_q    <= 1'b0;
            err_count_q <= err_count_d;
            if (r_fail && !first_seen_q) begin
              first_fail_q <= idx_q;
              first_seen_q <= 1'b1;
            end
            if (idx_q == LAST_IDX) begin
              state_q <= FINISH;
            end else begin
              idx_q     <= idx_q + 4'd1;
              state_q   <= RD_REQ;
              araddr_q  <= reg_addr(idx_q + 4'd1);
              arvalid_q <= 1'b1;
            end
          end
        end
        FINISH: begin
          // Outputs update on leaving FINISH, so start is next sampled in IDLE.
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          pass_q  <= (err_count_d == 5'd0);
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_count     = err_count_q;
  assign first_fail    = first_fail_q;
  assign M_AXI_AWADDR  = awaddr_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = araddr_q;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axi4lite_selftest_master.sv
// Bench for axi4lite_selftest_master. It drives dut0 (defaults) and dut1 (NUM_REGS=2, SEED=FFFF_FFFF)
// through a shared, configurable slave. The slave supports AW delay, R delay, and BRESP/RRESP/data faults.
// A transaction-level model predicts every address, data beat and the final result.
module tb_axi4lite_selftest_master;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        start0 = 1'b0, busy0, done0, pass0;
  logic [4:0]  err0;
  logic [3:0]  ff0, wstrb0;
  logic [31:0] awaddr0, wdata0, araddr0;
  logic [2:0]  awprot0, arprot0;
  logic        awvalid0, wvalid0, bready0, arvalid0, rready0;
  logic        start1 = 1'b0, busy1, done1, pass1;
  logic [4:0]  err1;
  logic [3:0]  ff1, wstrb1;
  logic [31:0] awaddr1, wdata1, araddr1;
  logic [2:0]  awprot1, arprot1;
  logic        awvalid1, wvalid1, bready1, arvalid1, rready1;

  logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
  logic [1:0]  bresp = 2'b00, rresp = 2'b00;
  logic [31:0] rdata = '0;

  axi4lite_selftest_master dut0 (
    .ACLK(clk), .ARESET(rst), .start(start0), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .first_fail(ff0),
    .M_AXI_AWADDR(awaddr0), .M_AXI_AWPROT(awprot0), .M_AXI_AWVALID(awvalid0), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata0), .M_AXI_WSTRB(wstrb0), .M_AXI_WVALID(wvalid0), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready0),
    .M_AXI_ARADDR(araddr0), .M_AXI_ARPROT(arprot0), .M_AXI_ARVALID(arvalid0), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready0));

  axi4lite_selftest_master #(.NUM_REGS(2), .SEED(32'hFFFF_FFFF)) dut1 (
    .ACLK(clk), .ARESET(rst), .start(start1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .first_fail(ff1),
    .M_AXI_AWADDR(awaddr1), .M_AXI_AWPROT(awprot1), .M_AXI_AWVALID(awvalid1), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata1), .M_AXI_WSTRB(wstrb1), .M_AXI_WVALID(wvalid1), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready1),
    .M_AXI_ARADDR(araddr1), .M_AXI_ARPROT(arprot1), .M_AXI_ARVALID(arvalid1), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready1));

  // The slave and the monitor look at whichever master is selected.
  logic sel = 1'b0;
  logic        m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, m_busy, m_done, m_pass;
  logic [31:0] m_awaddr, m_wdata, m_araddr;
  logic [2:0]  m_awprot, m_arprot;
  logic [3:0]  m_wstrb, m_ff;
  logic [4:0]  m_err;
  assign m_awvalid = sel ? awvalid1 : awvalid0;
  assign m_wvalid  = sel ? wvalid1  : wvalid0;
  assign m_bready  = sel ? bready1  : bready0;
  assign m_arvalid = sel ? arvalid1 : arvalid0;
  assign m_rready  = sel ? rready1  : rready0;
  assign m_busy    = sel ? busy1    : busy0;
  assign m_done    = sel ? done1    : done0;
  assign m_pass    = sel ? pass1    : pass0;
  assign m_awaddr  = sel ? awaddr1  : awaddr0;
  assign m_wdata   = sel ? wdata1   : wdata0;
  assign m_araddr  = sel ? araddr1  : araddr0;
  assign m_awprot  = sel ? awprot1  : awprot0;
  assign m_arprot  = sel ? arprot1  : arprot0;
  assign m_wstrb   = sel ? wstrb1   : wstrb0;
  assign m_ff      = sel ? ff1      : ff0;
  assign m_err     = sel ? err1     : err0;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  // ---------------- slave ----------------
  int          s_awdly = 0, s_rdly = 0, s_bidx = -1, s_ridx = -1;
  bit          s_cor_en = 1'b0;
  logic [31:0] s_cor_addr = '0;
  logic [31:0] mem [16];
  int          aw_wait = 0, r_wait = -1;
  bit          got_aw = 0, got_w = 0, aw_p = 0, w_p = 0, ar_p = 0, b_p = 0, r_p = 0;
  logic [31:0] cap_aw = '0, cap_w = '0, cap_ar = '0, s_aw = '0, s_w = '0, r_addr = '0;

  always @(negedge clk) begin
    if (rst) begin
      awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
      got_aw = 0; got_w = 0; aw_p = 0; w_p = 0; ar_p = 0; b_p = 0; r_p = 0;
      aw_wait = 0; r_wait = -1;
    end else begin
      // Retire the handshakes decided at the previous negedge.
      if (b_p) bvalid = 0;
      if (r_p) rvalid = 0;
      if (aw_p) begin got_aw = 1; s_aw = cap_aw; end
      if (w_p)  begin got_w = 1;  s_w = cap_w; end
      if (got_aw && got_w) begin
        mem[s_aw[5:2]] = s_w;
        bvalid = 1;
        bresp  = (int'(s_aw[5:2]) == s_bidx) ? 2'b10 : 2'b00;
        got_aw = 0; got_w = 0;
      end
      if (ar_p) begin r_wait = s_rdly; r_addr = cap_ar; end
      if (r_wait == 0) begin
        rvalid = 1;
        rdata  = (s_cor_en && r_addr == s_cor_addr) ? 32'hDEAD_BEEF : mem[r_addr[5:2]];
        rresp  = (int'(r_addr[5:2]) == s_ridx) ? 2'b10 : 2'b00;
        r_wait = -1;
      end else if (r_wait > 0) begin
        r_wait--;
      end
      if (m_awvalid && !got_aw) begin
        awready = (aw_wait >= s_awdly);
        aw_wait++;
      end else begin
        awready = 0; aw_wait = 0;
      end
      wready  = m_wvalid && !got_w;
      arready = m_arvalid;
      aw_p = m_awvalid && awready; cap_aw = m_awaddr;
      w_p  = m_wvalid && wready;   cap_w  = m_wdata;
      ar_p = m_arvalid && arready; cap_ar = m_araddr;
      b_p  = bvalid && m_bready;
      r_p  = rvalid && m_rready;
    end
  end

  // ---------------- model ----------------
  logic [31:0] exp_aw[$], exp_w[$], exp_ar[$];
  int          exp_n = 0;
  logic [31:0] exp_err = '0, exp_ff = '0, exp_pass = '0;

  task automatic prepare(input int n, input logic [31:0] seed, input int bidx, input int ridx,
                         input bit cor_en, input logic [31:0] cor_addr);
    int errs = 0;
    int ff = 0;
    bit found = 0;
    logic [31:0] want, got;
    for (int i = 0; i < n; i++) begin
      exp_aw.push_back(32'(4 * i));
      exp_w.push_back(seed + 32'(i));
      if (i == bidx) errs++;
    end
    for (int i = 0; i < n; i++) begin
      exp_ar.push_back(32'(4 * i));
      want = seed + 32'(i);
      got  = (cor_en && 32'(4 * i) == cor_addr) ? 32'hDEAD_BEEF : want;
      if (got != want || i == ridx) begin
        errs++;
        if (!found) ff = i;
        found = 1;
      end
    end
    if (errs > 31) errs = 31;
    exp_n = n; exp_err = 32'(errs); exp_ff = 32'(ff); exp_pass = (errs == 0) ? 32'd1 : 32'd0;
    s_bidx = bidx; s_ridx = ridx; s_cor_en = cor_en; s_cor_addr = cor_addr;
  endtask

  // ---------------- monitor / compare ----------------
  bit          mon_en = 0, aw_hold = 0, w_hold = 0, ar_hold = 0, w_first = 0;
  logic [31:0] aw_hold_a = '0, w_hold_d = '0, ar_hold_a = '0;
  int          b_cnt = 0, r_cnt = 0;
  logic [31:0] wlog_a[$], wlog_d[$];

  always @(negedge clk) begin
    #1;
    if (rst || !mon_en) begin
      aw_hold = 0; w_hold = 0; ar_hold = 0; b_cnt = 0; r_cnt = 0;
    end else begin
      chk("awprot", 32'(m_awprot), 32'd0);
      chk("arprot", 32'(m_arprot), 32'd0);
      chk("wstrb", 32'(m_wstrb), 32'hF);
      if (aw_hold) begin
        chk("aw_hold_valid", 32'(m_awvalid), 32'd1);
        chk("aw_hold_addr", m_awaddr, aw_hold_a);
      end
      if (w_hold) begin
        chk("w_hold_valid", 32'(m_wvalid), 32'd1);
        chk("w_hold_data", m_wdata, w_hold_d);
      end
      if (ar_hold) begin
        chk("ar_hold_valid", 32'(m_arvalid), 32'd1);
        chk("ar_hold_addr", m_araddr, ar_hold_a);
      end
      if (m_awvalid && awready) begin
        if (exp_aw.size() == 0) chk("aw_unexpected", 32'd1, 32'd0);
        else chk("awaddr", m_awaddr, exp_aw.pop_front());
        wlog_a.push_back(m_awaddr);
      end
      if (m_wvalid && wready) begin
        if (exp_w.size() == 0) chk("w_unexpected", 32'd1, 32'd0);
        else chk("wdata", m_wdata, exp_w.pop_front());
        wlog_d.push_back(m_wdata);
      end
      if (m_arvalid && arready) begin
        if (exp_ar.size() == 0) chk("ar_unexpected", 32'd1, 32'd0);
        else chk("araddr", m_araddr, exp_ar.pop_front());
      end
      aw_hold = m_awvalid && !awready; aw_hold_a = m_awaddr;
      w_hold  = m_wvalid && !wready;   w_hold_d  = m_wdata;
      ar_hold = m_arvalid && !arready; ar_hold_a = m_araddr;
      if (m_awvalid && !m_wvalid) w_first = 1;
      if (bvalid && m_bready) b_cnt++;
      if (rvalid && m_rready) r_cnt++;
      if (m_done) begin
        chk("busy_at_done", 32'(m_busy), 32'd0);
        chk("pass", 32'(m_pass), exp_pass);
        chk("err_count", 32'(m_err), exp_err);
        chk("first_fail", 32'(m_ff), exp_ff);
        chk("b_beats", b_cnt, exp_n);
        chk("r_beats", r_cnt, exp_n);
        b_cnt = 0; r_cnt = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic kick0();
    @(negedge clk); #2 start0 = 1'b1;
    @(posedge clk); #2 start0 = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    for (int k = 1; k <= 400; k++) begin
      @(posedge clk); @(negedge clk); #2;
      if (m_done) begin cyc = k; break; end
    end
    if (cyc == 0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    bit found;
    bit prev_done;
    int dcyc[$];
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    chk("rst_pass", 32'(pass0), 32'd0);
    chk("rst_err", 32'(err0), 32'd0);
    chk("rst_ff", 32'(ff0), 32'd0);
    chk("rst_valids", 32'({awvalid0, wvalid0, arvalid0, bready0, rready0}), 32'd0);
    chk("rst_addr_data", awaddr0 | wdata0 | araddr0, 32'd0);
    chk("rst_dut1", 32'({busy1, done1, awvalid1, wvalid1, arvalid1, bready1, rready1}), 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;

    // Ideal slave, defaults.
    wlog_a.delete(); wlog_d.delete();
    prepare(4, 32'h1, -1, -1, 1'b0, 32'h0);
    kick0();
    wait_done(lat);
    chk("t1_latency", lat, 32'd17);
    chk("t1_pass", 32'(pass0), 32'd1);
    chk("t1_err", 32'(err0), 32'd0);
    chk("t1_addr3", wlog_a[3], 32'hC);
    chk("t1_data0", wlog_d[0], 32'h1);
    chk("t1_data3", wlog_d[3], 32'h4);

    // AWREADY three cycles late, WREADY immediate.
    w_first = 0; s_awdly = 3;
    prepare(4, 32'h1, -1, -1, 1'b0, 32'h0);
    kick0();
    wait_done(lat);
    chk("t2_w_before_aw", 32'(w_first), 32'd1);
    chk("t2_pass", 32'(pass0), 32'd1);
    s_awdly = 0;

    // Corrupt read data at 0x8.
    prepare(4, 32'h1, -1, -1, 1'b1, 32'h8);
    kick0();
    wait_done(lat);
    chk("t3_pass", 32'(pass0), 32'd0);
    chk("t3_err", 32'(err0), 32'd1);
    chk("t3_ff", 32'(ff0), 32'd2);

    // SLVERR on write 1 and on read 3.
    prepare(4, 32'h1, 1, 3, 1'b0, 32'h0);
    kick0();
    wait_done(lat);
    chk("t4_pass", 32'(pass0), 32'd0);
    chk("t4_err", 32'(err0), 32'd2);
    chk("t4_ff", 32'(ff0), 32'd3);

    // Reset while the master waits in RD_RESP with RVALID low.
    s_rdly = 6;
    prepare(4, 32'h1, -1, -1, 1'b0, 32'h0);
    kick0();
    found = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk); #2;
      if (m_rready && !rvalid && m_araddr == 32'h8) begin found = 1; break; end
    end
    chk("t5_reached_rd_resp", 32'(found), 32'd1);
    rst = 1'b1;
    #1;
    chk("t5_rst_busy", 32'(busy0), 32'd0);
    chk("t5_rst_valids", 32'({awvalid0, wvalid0, arvalid0, bready0, rready0}), 32'd0);
    chk("t5_rst_addr_data", awaddr0 | wdata0 | araddr0, 32'd0);
    chk("t5_rst_err", 32'(err0), 32'd0);
    @(negedge clk); #2;
    chk("t5_rst_held", 32'({busy0, rready0, arvalid0}), 32'd0);
    rst = 1'b0;
    exp_aw.delete(); exp_w.delete(); exp_ar.delete();
    s_rdly = 0;
    prepare(4, 32'h1, -1, -1, 1'b0, 32'h0);
    kick0();
    wait_done(lat);
    chk("t5_pass", 32'(pass0), 32'd1);
    chk("t5_latency", lat, 32'd17);

    // start held high on the 2-register, wrapping-seed master.
    sel = 1'b1;
    wlog_a.delete(); wlog_d.delete();
    for (int r = 0; r < 4; r++) prepare(2, 32'hFFFF_FFFF, -1, -1, 1'b0, 32'h0);
    prev_done = 0;
    @(negedge clk); #2 start1 = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); @(negedge clk); #2;
      if (prev_done) chk("t6_reaccept", 32'(m_busy), 32'd1);
      prev_done = m_done;
      if (m_done) dcyc.push_back(c);
    end
    start1 = 1'b0;
    chk("t6_runs", dcyc.size(), 32'd4);
    chk("t6_done0", dcyc[0], 32'd9);
    chk("t6_done1", dcyc[1], 32'd19);
    chk("t6_done3", dcyc[3], 32'd39);
    chk("t6_data0", wlog_d[0], 32'hFFFF_FFFF);
    chk("t6_data1", wlog_d[1], 32'h0000_0000);
    chk("t6_addr1", wlog_a[1], 32'h4);
    repeat (5) @(negedge clk);
    #2;
    chk("t6_idle_after", 32'(busy1), 32'd0);
    chk("queues_drained", exp_aw.size() + exp_w.size() + exp_ar.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
